// File: rtl/bla_serial_sub_if.sv
// Handshake and operand/result bundle for the nibble-serial subtractor.
interface bla_serial_sub_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf, zero
    );
endinterface

// File: rtl/bla_serial_sub.sv
// Nibble-serial subtractor: diff = a - b - bin, one 4-bit borrow-lookahead slice per cycle.
module bla_serial_sub #(
    parameter int unsigned WIDTH = 16
) (
    input logic             clk,
    input logic             rst_n,
    bla_serial_sub_if.slave bus
);
    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;

    generate
        if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
            $error("bla_serial_sub: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_n;
    logic [WIDTH-1:0] a_q, a_n, b_q, b_n, work_q, work_n;
    logic             brw_q, brw_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic [WIDTH-1:0] diff_q, diff_n;
    logic             bout_q, bout_n, ovf_q, ovf_n, zero_q, zero_n;
    logic             in_ready_q, in_ready_n, out_valid_q, out_valid_n;

    // Current slice: operands are shifted down so the active nibble is always at [3:0]
    logic [3:0]       sa, sb, g, p, d;
    logic [4:0]       c;
    logic [WIDTH+3:0] work_cat;

    always_comb begin
        sa   = a_q[3:0];
        sb   = b_q[3:0];
        g    = ~sa & sb;
        p    = ~(sa ^ sb);
        c[0] = brw_q;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        d        = sa ^ sb ^ c[3:0];
        work_cat = {d, work_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            work_q      <= '0;
            brw_q       <= 1'b0;
            cnt_q       <= '0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_n;
            a_q         <= a_n;
            b_q         <= b_n;
            work_q      <= work_n;
            brw_q       <= brw_n;
            cnt_q       <= cnt_n;
            diff_q      <= diff_n;
            bout_q      <= bout_n;
            ovf_q       <= ovf_n;
            zero_q      <= zero_n;
            in_ready_q  <= in_ready_n;
            out_valid_q <= out_valid_n;
        end
    end

    always_comb begin
        state_n = state_q;
        a_n     = a_q;
        b_n     = b_q;
        work_n  = work_q;
        brw_n   = brw_q;
        cnt_n   = cnt_q;
        diff_n  = diff_q;
        bout_n  = bout_q;
        ovf_n   = ovf_q;
        zero_n  = zero_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_n     = bus.a;
                    b_n     = bus.b;
                    brw_n   = bus.bin;
                    cnt_n   = '0;
                    state_n = RUN;
                end
            end
            RUN: begin
                work_n = work_cat[WIDTH+3:4];
                a_n    = a_q >> 4;
                b_n    = b_q >> 4;
                brw_n  = c[4];
                if (cnt_q == CW'(NIB - 1)) begin
                    // Top slice: its bit 3 carries the operand sign bits for overflow
                    diff_n  = work_n;
                    bout_n  = c[4];
                    ovf_n   = (sa[3] ^ sb[3]) & (sa[3] ^ d[3]);
                    zero_n  = (work_n == '0);
                    state_n = DONE;
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        in_ready_n  = (state_n == IDLE);
        out_valid_n = (state_n == DONE);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_bla_serial_sub.sv
// Scoreboard bench for bla_serial_sub (WIDTH=16): directed vectors, stalls, reset abort, random ops.
module tb_bla_serial_sub;
    localparam int unsigned W   = 16;
    localparam int unsigned NIB = W / 4;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        logic         z;
    } exp_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        exp_t         e;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   cyc;
    int   ordy_mode;  // 0: always ready, 1: random stalls, 2: held low
    exp_t exp_q[$];
    int   acc_q[$];
    vec_t vecs[8];

    bla_serial_sub_if #(.WIDTH(W)) bus ();
    bla_serial_sub #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        logic [W:0] r;
        r        = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
        model.d  = r[W-1:0];
        model.bo = r[W];
        model.ov = (a[W-1] ^ b[W-1]) & (a[W-1] ^ r[W-1]);
        model.z  = (r[W-1:0] == '0);
    endfunction

    // out_ready changes shortly after the rising edge so it is stable for the next edge
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ordy_mode)
                1:       bus.out_ready = 1'($urandom_range(1, 0));
                2:       bus.out_ready = 1'b0;
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: compares every cycle the result is presented; pops on handshake
    initial begin : monitor
        logic prev_ov;
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ov = 1'b0;
            end else begin
                if (bus.out_valid) begin
                    check("in_ready_low_in_done", 32'(bus.in_ready), 32'd0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
                    end else begin
                        check("diff", 32'(bus.diff), 32'(exp_q[0].d));
                        check("bout", 32'(bus.bout), 32'(exp_q[0].bo));
                        check("ovf",  32'(bus.ovf),  32'(exp_q[0].ov));
                        check("zero", 32'(bus.zero), 32'(exp_q[0].z));
                        if (!prev_ov && acc_q.size() > 0) begin
                            check("latency", 32'(cyc - acc_q.pop_front()), 32'(NIB));
                        end
                        if (bus.out_ready) void'(exp_q.pop_front());
                    end
                end
                prev_ov = bus.out_valid;
            end
        end
    end

    // Caller is at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, input exp_t e);
        int n;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        end else begin
            bus.a        = a;
            bus.b        = b;
            bus.bin      = bin;
            bus.in_valid = 1'b1;
            exp_q.push_back(e);
            acc_q.push_back(cyc + 1);
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : driver
        logic [W-1:0] ra, rb;
        logic         rbin;
        int           n;
        n_cmp = 0; n_err = 0; cyc = 0; ordy_mode = 0;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
        vecs[0] = '{16'h1234, 16'h0234, 1'b0, '{16'h1000, 1'b0, 1'b0, 1'b0}};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, '{16'hFFFF, 1'b1, 1'b0, 1'b0}};
        vecs[2] = '{16'h8000, 16'h0001, 1'b0, '{16'h7FFF, 1'b0, 1'b1, 1'b0}};
        vecs[3] = '{16'h5555, 16'h5554, 1'b1, '{16'h0000, 1'b0, 1'b0, 1'b1}};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, '{16'hFFFF, 1'b1, 1'b0, 1'b0}};
        vecs[5] = '{16'h7FFF, 16'hFFFF, 1'b0, '{16'h8000, 1'b1, 1'b1, 1'b0}};
        vecs[6] = '{16'h0000, 16'h0000, 1'b1, '{16'hFFFF, 1'b1, 1'b0, 1'b0}};
        vecs[7] = '{16'h0000, 16'h0000, 1'b0, '{16'h0000, 1'b0, 1'b0, 1'b1}};

        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_diff",      32'(bus.diff),      32'd0);
        check("rst_flags",     32'({bus.bout, bus.ovf, bus.zero}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors, one at a time then back to back
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].e);
            drain();
        end
        for (int i = 0; i < 8; i++) send(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].e);
        drain();

        // Consumer stall: result must hold while inputs churn
        ordy_mode = 2;
        send(16'h1234, 16'h0234, 1'b0, '{16'h1000, 1'b0, 1'b0, 1'b0});
        n = 0;
        while (!bus.out_valid && n < 50) begin @(negedge clk); n++; end
        check("stall_out_valid", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = 16'($urandom);
            bus.b        = 16'($urandom);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        ordy_mode    = 0;
        n = 0;
        while (bus.out_valid && n < 10) begin @(negedge clk); n++; end
        check("release_out_valid", 32'(bus.out_valid), 32'd0);
        check("release_in_ready",  32'(bus.in_ready),  32'd1);
        check("release_no_accept", 32'(exp_q.size()),  32'd0);

        // Reset two cycles into RUN abandons the operation
        send(16'hABCD, 16'h0123, 1'b0, '{16'hAAAA, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        acc_q.delete();
        check("abort_in_ready",  32'(bus.in_ready),  32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_diff",      32'(bus.diff),      32'd0);
        check("abort_flags",     32'({bus.bout, bus.ovf, bus.zero}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (8) @(negedge clk);
        send(16'h0010, 16'h0001, 1'b0, '{16'h000F, 1'b0, 1'b0, 1'b0});
        drain();

        // Random back-to-back operations with random consumer stalls
        ordy_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom_range(1, 0));
            if (i % 16 == 0) rb = ra;
            send(ra, rb, rbin, model(ra, rb, rbin));
        end
        drain();
        ordy_mode = 0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d compared, required completion", n_cmp);
        $fatal(1, "watchdog expired");
    end
endmodule
